// File: rtl/rv32_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs plus stall/flush/cancel controls and status.
interface rv32_hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           id_rs1_in;
    logic [4:0]           id_rs2_in;
    logic                 id_rs1_used_in;
    logic                 id_rs2_used_in;
    logic [4:0]           ex_rd_in;
    logic                 ex_rd_writeback_in;
    logic                 ex_mem_read_en_in;
    logic [4:0]           mem_rd_in;
    logic                 mem_rd_writeback_in;
    logic                 mem_req_in;
    logic                 mem_ready_in;
    logic                 branch_taken_in;
    logic                 fetch_stall_out;
    logic                 decode_stall_out;
    logic                 execute_stall_out;
    logic                 fetch_flush_out;
    logic                 decode_flush_out;
    logic                 execute_flush_out;
    logic                 mem_flush_out;
    logic                 mem_cancel_out;
    logic                 timeout_err_out;
    logic [CNT_WIDTH-1:0] stall_count_out;

    modport master (
        output id_rs1_in, id_rs2_in, id_rs1_used_in, id_rs2_used_in,
               ex_rd_in, ex_rd_writeback_in, ex_mem_read_en_in,
               mem_rd_in, mem_rd_writeback_in, mem_req_in, mem_ready_in,
               branch_taken_in,
        input  fetch_stall_out, decode_stall_out, execute_stall_out,
               fetch_flush_out, decode_flush_out, execute_flush_out,
               mem_flush_out, mem_cancel_out, timeout_err_out, stall_count_out
    );

    modport slave (
        input  id_rs1_in, id_rs2_in, id_rs1_used_in, id_rs2_used_in,
               ex_rd_in, ex_rd_writeback_in, ex_mem_read_en_in,
               mem_rd_in, mem_rd_writeback_in, mem_req_in, mem_ready_in,
               branch_taken_in,
        output fetch_stall_out, decode_stall_out, execute_stall_out,
               fetch_flush_out, decode_flush_out, execute_flush_out,
               mem_flush_out, mem_cancel_out, timeout_err_out, stall_count_out
    );
endinterface

// File: rtl/rv32_hazard_ctrl.sv
// rv32 pipeline hazard controller: branch flush, mem wait/timeout FSM, RAW stalls, stall counter.
// Build option RV32_FORWARD_EN: with EX/MEM forwarding only load-use hazards stall.
module rv32_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               reset,
    rv32_hazard_ctrl_if.slave  hz
);
    localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TIMEOUT_V = WW'(MEM_TIMEOUT);

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [WW-1:0]        wait_cnt, wait_nxt;
    logic                 err, err_set;
    logic [CNT_WIDTH-1:0] cnt;

    logic fs, ds, es, ff, df, ef, mf, mc;
    logic hazard;

    function automatic logic reads(input logic [4:0] rd);
        return (rd != 5'd0) &&
               ((hz.id_rs1_used_in && (hz.id_rs1_in == rd)) ||
                (hz.id_rs2_used_in && (hz.id_rs2_in == rd)));
    endfunction

`ifdef RV32_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = ^{hz.mem_rd_in, hz.mem_rd_writeback_in};
    assign hazard = hz.ex_mem_read_en_in && hz.ex_rd_writeback_in && reads(hz.ex_rd_in);
`else
    // Writeback-stage producers are covered by the decode bypass, so only EX and MEM are checked.
    assign hazard = (hz.ex_rd_writeback_in && reads(hz.ex_rd_in)) ||
                    (hz.mem_rd_writeback_in && reads(hz.mem_rd_in));
`endif

    always_comb begin
        fs = 1'b0; ds = 1'b0; es = 1'b0;
        ff = 1'b0; df = 1'b0; ef = 1'b0;
        mf = 1'b0; mc = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        if (hz.branch_taken_in) begin
            ff = 1'b1; df = 1'b1; ef = 1'b1;
            mc = hz.mem_req_in;
            state_nxt = RUN;
            wait_nxt  = '0;
        end else if (state == WAIT && !hz.mem_ready_in) begin
            if (wait_cnt < TIMEOUT_V) begin
                fs = 1'b1; ds = 1'b1; es = 1'b1; mf = 1'b1;
                wait_nxt = wait_cnt + 1'b1;
            end else begin
                mf = 1'b1; mc = 1'b1;
                err_set   = 1'b1;
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        end else if (state == RUN && hz.mem_req_in && !hz.mem_ready_in) begin
            fs = 1'b1; ds = 1'b1; es = 1'b1; mf = 1'b1;
            state_nxt = WAIT;
            wait_nxt  = WW'(1);
        end else begin
            if (state == WAIT) begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
            if (hazard) begin
                fs = 1'b1; ds = 1'b1; ef = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set)
                err <= 1'b1;
            if ((fs || ds || es) && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        hz.fetch_stall_out   = fs;
        hz.decode_stall_out  = ds;
        hz.execute_stall_out = es;
        hz.fetch_flush_out   = ff;
        hz.decode_flush_out  = df;
        hz.execute_flush_out = ef;
        hz.mem_flush_out     = mf;
        hz.mem_cancel_out    = mc;
        hz.timeout_err_out   = err;
        hz.stall_count_out   = cnt;
    end
endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Table/sequence bench for rv32_hazard_ctrl with a scoreboard queue of expected control vectors.
module tb_rv32_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;

    // Control vector order: {fs, ds, es, ff, df, ef, mf, mc}
    localparam logic [7:0] P_NONE = 8'b0000_0000;
    localparam logic [7:0] P_LU   = 8'b1100_0100;
    localparam logic [7:0] P_MW   = 8'b1110_0010;
    localparam logic [7:0] P_BR   = 8'b0001_1100;
    localparam logic [7:0] P_BRC  = 8'b0001_1101;
    localparam logic [7:0] P_TO   = 8'b0000_0011;
`ifdef RV32_FORWARD_EN
    localparam logic [7:0] P_RAW  = P_NONE;
`else
    localparam logic [7:0] P_RAW  = P_LU;
`endif

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exrd;
        logic       exwb, exld;
        logic [4:0] memrd;
        logic       memwb, req, rdy, br;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rv32_hazard_ctrl_if #(.CNT_WIDTH(CW)) bus ();
    rv32_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] expq[$];
    logic [CW-1:0] exp_cnt = '0;
    logic exp_err = 1'b0;
    vec_t tbl[12];

    function automatic vec_t mk(input string n, input logic rst,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic [4:0] exrd, input logic exwb, input logic exld,
                                input logic [4:0] memrd, input logic memwb,
                                input logic req, input logic rdy, input logic br,
                                input logic [7:0] exp);
        vec_t v;
        v.name = n; v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exrd = exrd; v.exwb = exwb; v.exld = exld; v.memrd = memrd; v.memwb = memwb;
        v.req = req; v.rdy = rdy; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string n, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", n, got, want);
        end
    endtask

    task automatic step(input vec_t v);
        logic [7:0] got, e;
        @(posedge clk);
        #1;
        reset                   = v.rst;
        bus.id_rs1_in           = v.rs1;
        bus.id_rs2_in           = v.rs2;
        bus.id_rs1_used_in      = v.u1;
        bus.id_rs2_used_in      = v.u2;
        bus.ex_rd_in            = v.exrd;
        bus.ex_rd_writeback_in  = v.exwb;
        bus.ex_mem_read_en_in   = v.exld;
        bus.mem_rd_in           = v.memrd;
        bus.mem_rd_writeback_in = v.memwb;
        bus.mem_req_in          = v.req;
        bus.mem_ready_in        = v.rdy;
        bus.branch_taken_in     = v.br;
        expq.push_back(v.exp);
        @(negedge clk);
        got = {bus.fetch_stall_out, bus.decode_stall_out, bus.execute_stall_out,
               bus.fetch_flush_out, bus.decode_flush_out, bus.execute_flush_out,
               bus.mem_flush_out, bus.mem_cancel_out};
        e = expq.pop_front();
        check({v.name, " ctrl"}, got, e);
        check({v.name, " count"}, 8'(bus.stall_count_out), 8'(exp_cnt));
        check({v.name, " err"}, 8'(bus.timeout_err_out), 8'(exp_err));
        if (v.rst) begin
            exp_cnt = '0;
            exp_err = 1'b0;
        end else begin
            if ((e[7:5] != 3'b000) && (exp_cnt != '1))
                exp_cnt = exp_cnt + 1'b1;
            if (e == P_TO)
                exp_err = 1'b1;
        end
    endtask

    // Shorthand constructors for the sequences
    function automatic vec_t idle(input string n, input logic [7:0] exp);
        return mk(n, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endfunction

    function automatic vec_t memv(input string n, input logic rst, input logic req,
                                  input logic rdy, input logic br, input logic [7:0] exp);
        return mk(n, rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, req, rdy, br, exp);
    endfunction

    initial begin
        tbl[0]  = mk("all_zero",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, P_NONE);
        tbl[1]  = mk("lu_rs1",       0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0, P_LU);
        tbl[2]  = mk("lu_rd0",       0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, P_NONE);
        tbl[3]  = mk("lu_unused",    0, 5'd5, 5'd3, 0, 1, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0, P_NONE);
        tbl[4]  = mk("lu_rs2",       0, 5'd1, 5'd6, 1, 1, 5'd6, 1, 1, 5'd0, 0, 0, 0, 0, P_LU);
        tbl[5]  = mk("lu_no_wb",     0, 5'd5, 5'd0, 1, 0, 5'd5, 0, 1, 5'd0, 0, 0, 0, 0, P_NONE);
        tbl[6]  = mk("alu_ex_raw",   0, 5'd2, 5'd7, 1, 1, 5'd7, 1, 0, 5'd0, 0, 0, 0, 0, P_RAW);
        tbl[7]  = mk("mem_raw",      0, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 0, P_RAW);
        tbl[8]  = mk("br_over_lu",   0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 1, 1, 1, P_BRC);
        tbl[9]  = mk("br_noreq",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, P_BR);
        tbl[10] = mk("mem_0wait",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, P_NONE);
        tbl[11] = mk("mem_rd0",      0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, P_NONE);

        for (int unsigned i = 0; i < 3; i++)
            step(memv("reset", 1'b1, 1'b0, 1'b0, 1'b0, P_NONE));

        for (int unsigned i = 0; i < 12; i++)
            step(tbl[i]);

        // Load-use: one bubble with forwarding, two without
        step(mk("lu_seq_a", 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0, P_LU));
        step(mk("lu_seq_b", 0, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 0, P_RAW));
        step(mk("lu_seq_c", 0, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, P_NONE));

        // ALU producer rd=7, consumer rs2=7
        step(mk("alu_seq_a", 0, 5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 5'd0, 0, 0, 0, 0, P_RAW));
`ifdef RV32_FORWARD_EN
        step(mk("alu_seq_b", 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, P_NONE));
`else
        step(mk("alu_seq_b", 0, 5'd0, 5'd7, 0, 1, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0, P_LU));
`endif
        step(mk("alu_seq_c", 0, 5'd0, 5'd7, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, P_NONE));

        // Three wait states then ready
        for (int unsigned i = 0; i < 3; i++)
            step(memv("mw_wait", 1'b0, 1'b1, 1'b0, 1'b0, P_MW));
        step(memv("mw_ready", 1'b0, 1'b1, 1'b1, 1'b0, P_NONE));
        step(idle("mw_after", P_NONE));

        // Ready never arrives: TO stall cycles then forced release
        for (int unsigned i = 0; i < TO; i++)
            step(memv("to_wait", 1'b0, 1'b1, 1'b0, 1'b0, P_MW));
        step(memv("to_release", 1'b0, 1'b1, 1'b0, 1'b0, P_TO));
        step(idle("to_after", P_NONE));
        step(idle("to_sticky", P_NONE));

        // Branch during WAIT
        step(memv("bw_enter", 1'b0, 1'b1, 1'b0, 1'b0, P_MW));
        step(memv("bw_branch", 1'b0, 1'b1, 1'b0, 1'b1, P_BRC));
        step(idle("bw_run", P_NONE));

        // Reset while in WAIT
        step(memv("rw_enter", 1'b0, 1'b1, 1'b0, 1'b0, P_MW));
        step(memv("rw_reset", 1'b1, 1'b1, 1'b0, 1'b0, P_MW));
        step(idle("rw_run", P_NONE));
        step(idle("rw_final", P_NONE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
